// File: rtl/fwnoc_bridge_pkg.sv
// Shared constants and helpers for the fwnoc credit bridge and its RX FIFO.
// err bit indices are only meaningful when FWNOC_CREDIT_BRIDGE_ERR_EN is defined.
package fwnoc_bridge_pkg;

    localparam int ERR_RX_OVF = 0;
    localparam int ERR_TX_OVF = 1;

    // Bits needed to hold the values 0..n inclusive, i.e. ceil(log2(n+1)).
    function automatic int clog2p1(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fwnoc_credit_fifo.sv
// Small circular FIFO with occupancy count, used for the RX flit buffer.
// Pushes while full and pops while empty are ignored, so callers may be simple.
module fwnoc_credit_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset so it can map onto plain RAM/flop arrays.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwnoc_credit_bridge.sv
// Credit NoC link <-> valid/ready stream adapter for one NoC plane.
// Define FWNOC_CREDIT_BRIDGE_ERR_EN to build the sticky overflow error register.
module fwnoc_credit_bridge
    import fwnoc_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RX_DEPTH   = 4,
    parameter int TX_CREDITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c2b_valid,
    input  logic [DATA_WIDTH-1:0] c2b_data,
    output logic                  c2b_yummy,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  b2c_valid,
    output logic [DATA_WIDTH-1:0] b2c_data,
    input  logic                  b2c_yummy,
    output logic [1:0]            err
);

    localparam int             CW       = clog2p1(TX_CREDITS);
    localparam logic [CW-1:0]  CRED_MAX = CW'(TX_CREDITS);

    logic [$clog2(RX_DEPTH):0] rx_count;
    logic                      rx_full;
    logic                      rx_empty;
    logic [DATA_WIDTH-1:0]     rx_head;
    logic                      rx_push;
    logic                      rx_pop;
    logic [CW-1:0]             credits;
    logic                      send;
    logic                      tx_sat;

    // A flit arriving while full is dropped even if a pop frees a slot this cycle.
    assign rx_push = c2b_valid && !rx_full;
    assign m_valid = (rx_count != '0);
    assign m_data  = rx_empty ? '0 : rx_head;
    assign rx_pop  = m_valid && m_ready;

    fwnoc_credit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (c2b_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            c2b_yummy <= 1'b0;
        end else begin
            c2b_yummy <= rx_pop;
        end
    end

    assign s_ready = (credits != '0);
    assign send    = s_valid && s_ready;
    assign tx_sat  = b2c_yummy && !send && (credits == CRED_MAX);

    // A yummy that would exceed the chip buffer depth is absorbed, not counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            credits <= CRED_MAX;
        end else if (send && !b2c_yummy) begin
            credits <= credits - 1'b1;
        end else if (b2c_yummy && !send && !tx_sat) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b2c_valid <= 1'b0;
            b2c_data  <= '0;
        end else begin
            b2c_valid <= send;
            if (send) begin
                b2c_data <= s_data;
            end
        end
    end

`ifdef FWNOC_CREDIT_BRIDGE_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (c2b_valid && rx_full) begin
                err_q[ERR_RX_OVF] <= 1'b1;
            end
            if (tx_sat) begin
                err_q[ERR_TX_OVF] <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_fwnoc_credit_bridge.sv
// Self-checking bench for fwnoc_credit_bridge: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_fwnoc_credit_bridge;

    localparam int DW  = 64;
    localparam int RXD = 4;
    localparam int TXC = 4;

`ifdef FWNOC_CREDIT_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          c2b_valid;
    logic [DW-1:0] c2b_data;
    logic          c2b_yummy;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          b2c_valid;
    logic [DW-1:0] b2c_data;
    logic          b2c_yummy;
    logic [1:0]    err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fwnoc_credit_bridge #(
        .DATA_WIDTH (DW),
        .RX_DEPTH   (RXD),
        .TX_CREDITS (TXC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .c2b_valid (c2b_valid),
        .c2b_data  (c2b_data),
        .c2b_yummy (c2b_yummy),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .b2c_valid (b2c_valid),
        .b2c_data  (b2c_data),
        .b2c_yummy (b2c_yummy),
        .err       (err)
    );

    // Reference model: RX buffer as a queue, TX credits as an integer.
    logic [DW-1:0] mq[$];
    int            mcred;
    logic          my;
    logic          mbv;
    logic [DW-1:0] mbd;
    logic [1:0]    merr;

    typedef struct {
        logic          cv;
        logic [DW-1:0] cd;
        logic          mr;
        logic          sv;
        logic [DW-1:0] sd;
        logic          by;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          e_cy;
        logic          e_sr;
        logic          e_bv;
        logic [DW-1:0] e_bd;
        logic [1:0]    e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        logic accept;
        logic pop;
        logic snd;
        if (reset) begin
            mq.delete();
            mcred = TXC;
            my    = 1'b0;
            mbv   = 1'b0;
            mbd   = '0;
            merr  = 2'b00;
        end else begin
            accept = c2b_valid && (mq.size() < RXD);
            pop    = (mq.size() != 0) && m_ready;
            snd    = s_valid && (mcred > 0);
            if (c2b_valid && !accept) merr[0] = 1'b1;
            if (pop) void'(mq.pop_front());
            if (accept) mq.push_back(c2b_data);
            my  = pop;
            mbv = snd;
            if (snd) mbd = s_data;
            if (snd && !b2c_yummy) begin
                mcred = mcred - 1;
            end else if (!snd && b2c_yummy) begin
                if (mcred == TXC) merr[1] = 1'b1;
                else mcred = mcred + 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [DW-1:0] cd, input logic mr,
                                 input logic sv, input logic [DW-1:0] sd, input logic by);
        reset     = 1'b0;
        c2b_valid = cv;
        c2b_data  = cd;
        m_ready   = mr;
        s_valid   = sv;
        s_data    = sd;
        b2c_yummy = by;
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset(input logic mr);
        reset     = 1'b1;
        c2b_valid = 1'b0;
        c2b_data  = '0;
        m_ready   = mr;
        s_valid   = 1'b0;
        s_data    = '0;
        b2c_yummy = 1'b0;
        modelStep();
        @(posedge clock);
        #1;
        reset   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".m_valid"}, m_valid, (mq.size() != 0));
        if (mq.size() != 0) check({tag, ".m_data"}, m_data, mq[0]);
        check({tag, ".c2b_yummy"}, c2b_yummy, my);
        check({tag, ".s_ready"}, s_ready, (mcred != 0));
        check({tag, ".b2c_valid"}, b2c_valid, mbv);
        if (mbv) check({tag, ".b2c_data"}, b2c_data, mbd);
        check({tag, ".err"}, err, ERR_EN ? merr : 2'b00);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".m_valid"}, m_valid, 0);
        check({tag, ".m_data"}, m_data, 0);
        check({tag, ".c2b_yummy"}, c2b_yummy, 0);
        check({tag, ".s_ready"}, s_ready, 1);
        check({tag, ".b2c_valid"}, b2c_valid, 0);
        check({tag, ".b2c_data"}, b2c_data, 0);
        check({tag, ".err"}, err, 0);
    endtask

    // Counts b2c flits with s_valid held high for n cycles.
    task automatic countSends(input int n, output int sends);
        sends = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, '0, 0, 1, DW'(64'hC0 + i), 0);
            checkOutput("count_sends");
            if (b2c_valid) sends++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] e_rx;
        int         sends;
        int         sc;
        int         sent;
        int         recv;
        int         ycount;
        int         cyc;

        e_rx = ERR_EN ? 2'b01 : 2'b00;
        //          cv cd        mr sv sd        by  mv md        cy sr bv bd        err
        vecs[0] = '{1, 64'h11,   0, 0, 64'h0,    0,  1, 64'h11,   0, 1, 0, 64'h0,    2'b00};
        vecs[1] = '{1, 64'h12,   0, 0, 64'h0,    0,  1, 64'h11,   0, 1, 0, 64'h0,    2'b00};
        vecs[2] = '{1, 64'h13,   0, 0, 64'h0,    0,  1, 64'h11,   0, 1, 0, 64'h0,    2'b00};
        vecs[3] = '{1, 64'h14,   0, 0, 64'h0,    0,  1, 64'h11,   0, 1, 0, 64'h0,    2'b00};
        vecs[4] = '{1, 64'h15,   0, 0, 64'h0,    0,  1, 64'h11,   0, 1, 0, 64'h0,    e_rx};
        vecs[5] = '{0, 64'h0,    1, 0, 64'h0,    0,  1, 64'h12,   1, 1, 0, 64'h0,    e_rx};
        vecs[6] = '{1, 64'h16,   1, 0, 64'h0,    0,  1, 64'h13,   1, 1, 0, 64'h0,    e_rx};
        vecs[7] = '{0, 64'h0,    0, 1, 64'hA1,   0,  1, 64'h13,   0, 1, 1, 64'hA1,   e_rx};
        vecs[8] = '{0, 64'h0,    0, 1, 64'hA2,   1,  1, 64'h13,   0, 1, 1, 64'hA2,   e_rx};
        vecs[9] = '{0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h13,   0, 1, 0, 64'h0,    e_rx};

        // Reset and idle.
        doReset(0);
        checkResetValues("reset");
        for (int i = 0; i < 10; i++) applyStimulus(0, '0, 0, 0, '0, 0);
        checkResetValues("idle10");
        countSends(6, sends);
        check("reset_credits", sends, TXC);

        // Vector table: fill, overflow drop, pop/yummy, push+pop, TX send.
        doReset(0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].cv, vecs[i].cd, vecs[i].mr, vecs[i].sv, vecs[i].sd, vecs[i].by);
            check($sformatf("vec%0d.m_valid", i), m_valid, vecs[i].e_mv);
            check($sformatf("vec%0d.m_data", i), m_data, vecs[i].e_md);
            check($sformatf("vec%0d.c2b_yummy", i), c2b_yummy, vecs[i].e_cy);
            check($sformatf("vec%0d.s_ready", i), s_ready, vecs[i].e_sr);
            check($sformatf("vec%0d.b2c_valid", i), b2c_valid, vecs[i].e_bv);
            if (vecs[i].e_bv) check($sformatf("vec%0d.b2c_data", i), b2c_data, vecs[i].e_bd);
            check($sformatf("vec%0d.err", i), err, vecs[i].e_err);
        end

        // TX credit exhaustion, then a single yummy releases exactly one flit.
        doReset(0);
        countSends(8, sends);
        check("tx_exhaust_sends", sends, TXC);
        check("tx_exhaust_s_ready", s_ready, 0);
        applyStimulus(0, '0, 0, 1, 64'hD0, 1);
        checkOutput("tx_yummy");
        check("tx_yummy_s_ready", s_ready, 1);
        check("tx_yummy_no_send", b2c_valid, 0);
        applyStimulus(0, '0, 0, 1, 64'hD1, 0);
        check("tx_resend_valid", b2c_valid, 1);
        check("tx_resend_data", b2c_data, 64'hD1);
        check("tx_resend_s_ready", s_ready, 0);
        countSends(3, sends);
        check("tx_after_resend", sends, 0);

        // Yummy while credits are already full saturates.
        doReset(0);
        applyStimulus(0, '0, 0, 0, '0, 1);
        check("sat_s_ready", s_ready, 1);
        check("sat_err", err, ERR_EN ? 2'b10 : 2'b00);
        countSends(6, sends);
        check("sat_credits", sends, TXC);

        // Reset with buffered RX flits and outstanding TX credits.
        doReset(0);
        applyStimulus(1, 64'h31, 0, 1, 64'hE0, 0);
        applyStimulus(1, 64'h32, 0, 1, 64'hE1, 0);
        applyStimulus(1, 64'h33, 0, 0, '0, 0);
        checkOutput("pre_reset");
        doReset(1);
        check("midreset_m_valid", m_valid, 0);
        check("midreset_yummy", c2b_yummy, 0);
        check("midreset_s_ready", s_ready, 1);
        check("midreset_err", err, 0);
        applyStimulus(0, '0, 1, 0, '0, 0);
        check("postreset_yummy", c2b_yummy, 0);
        check("postreset_m_valid", m_valid, 0);
        countSends(6, sends);
        check("postreset_credits", sends, TXC);

        // RX streaming: credit-limited sender against an always-ready sink.
        doReset(0);
        sc = RXD; sent = 0; recv = 0; ycount = 0; cyc = 0;
        while ((recv < 20 || ycount < 20) && cyc < 40) begin
            logic cv;
            if (m_valid) begin
                check($sformatf("stream_order%0d", recv), m_data, DW'(64'h100 + recv));
                recv++;
            end
            cv = (sc > 0) && (sent < 20);
            applyStimulus(cv, DW'(64'h100 + sent), 1, 0, '0, 0);
            if (cv) begin
                sc--;
                sent++;
            end
            checkOutput("stream");
            if (c2b_yummy) begin
                sc++;
                ycount++;
            end
            cyc++;
        end
        check("stream_recv", recv, 20);
        check("stream_yummies", ycount, 20);
        check("stream_full_rate", (cyc <= 22), 1);

        // Randomized traffic against the reference model.
        doReset(0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset($urandom_range(0, 1));
            end else begin
                applyStimulus($urandom_range(0, 1), {$urandom, $urandom},
                              ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                              {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
            end
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
